// File: rtl/intdiv_sd2_acc_pkg.sv
// Purpose : shared SD2 digit encodings, command op codes and digit helpers for the intdiv SD2 accumulator.
// Latency : n/a (package).
// Backpressure: n/a (package).
// Contents: SD_ZERO/SD_POS1/SD_NEG1 digit codes, op_e command codes, sd_canon() digit canonicaliser.
package intdiv_sd2_acc_pkg;

  // Digit (p,n) encodes value p-n; 2'b11 is legal on input and means zero.
  localparam logic [1:0] SD_ZERO = 2'b00;
  localparam logic [1:0] SD_POS1 = 2'b10;
  localparam logic [1:0] SD_NEG1 = 2'b01;

  typedef enum logic [1:0] {
    OP_LOAD = 2'b00,
    OP_SUB  = 2'b01,
    OP_ADD  = 2'b10,
    OP_SHL  = 2'b11
  } op_e;

  // Fold the redundant zero (11) onto 00 so every driven digit is canonical.
  function automatic logic [1:0] sd_canon(input logic [1:0] d);
    return (d == 2'b11) ? SD_ZERO : d;
  endfunction

endpackage

// File: rtl/intdiv_sd2_digit.sv
// Purpose : one SD2 digit cell; splits digit +/- b into an outgoing transfer c and an interim s.
// Latency : combinational.
// Backpressure: none (pure function of its inputs).
// Ports   : digit (p,n) in, b divisor bit in, op_add (1=add,0=sub) in; c transfer out, s interim magnitude out.
module intdiv_sd2_digit
  import intdiv_sd2_acc_pkg::*;
(
  input  logic [1:0] digit,
  input  logic       b,
  input  logic       op_add,
  output logic       c,
  output logic       s
);

  logic w_p;
  logic w_n;

  // Treat the redundant 11 as zero before any arithmetic.
  assign w_p = digit[1] & ~digit[0];
  assign w_n = digit[0] & ~digit[1];

  // |s| is the parity of t = p - n +/- b in both modes.
  assign s = w_p ^ w_n ^ b;

  // Add: t = p-n+b, transfer when t >= 1.  Sub: t = p-n-b, transfer when t < 0.
  assign c = op_add ? (w_p | (b & ~w_n))
                    : (w_n | (b & ~w_p));

endmodule

// File: rtl/intdiv_sd2_acc.sv
// Purpose : W-digit SD2 partial-remainder register with carry-free LOAD/SUB/ADD/SHL and a registered result.
// Latency : 1 clk from command accept to res_valid with updated acc/msd_out; 1 op/clk back-to-back.
// Backpressure: cmd_ready = ~res_valid | res_ready; while a result is held unconsumed all state holds.
// Ports   : clk, rst (sync, active-high); cmd_valid/cmd_ready/cmd_op/cmd_sd/cmd_bin command side;
//           res_valid/res_ready result handshake; acc (W SD2 digits) and msd_out (weight 2^W digit).
module intdiv_sd2_acc
  import intdiv_sd2_acc_pkg::*;
#(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           cmd_valid,
  output logic           cmd_ready,
  input  logic [1:0]     cmd_op,
  input  logic [2*W-1:0] cmd_sd,
  input  logic [W-1:0]   cmd_bin,
  output logic           res_valid,
  input  logic           res_ready,
  output logic [2*W-1:0] acc,
  output logic [1:0]     msd_out
);

  logic [2*W-1:0] r_acc;
  logic [1:0]     r_msd;
  logic           r_res_valid;

  logic           w_accept;
  logic           w_op_add;
  logic [W-1:0]   w_c;
  logic [W-1:0]   w_s;
  logic [W-1:0]   w_cin;
  logic [2*W-1:0] w_arith_acc;
  logic [2*W-1:0] w_load_acc;
  logic [1:0]     w_arith_msd;
  logic [2*W-1:0] w_nxt_acc;
  logic [1:0]     w_nxt_msd;

  assign cmd_ready = ~r_res_valid | res_ready;
  assign w_accept  = cmd_valid & cmd_ready;
  assign w_op_add  = (op_e'(cmd_op) == OP_ADD);

  // Each digit only sees its right-hand neighbour's transfer: no carry chain.
  assign w_cin = {w_c[W-2:0], 1'b0};

  for (genvar gi = 0; gi < W; gi++) begin : g_digit
    intdiv_sd2_digit u_digit (
      .digit  (r_acc[2*gi +: 2]),
      .b      (cmd_bin[gi]),
      .op_add (w_op_add),
      .c      (w_c[gi]),
      .s      (w_s[gi])
    );

    // Add: digit = c_in + s (s <= 0) -> (c_in, |s|).  Sub: digit = s - c_in -> (s, c_in).
    assign w_arith_acc[2*gi +: 2] = sd_canon(w_op_add ? {w_cin[gi], w_s[gi]}
                                                      : {w_s[gi], w_cin[gi]});
    assign w_load_acc[2*gi +: 2]  = sd_canon(cmd_sd[2*gi +: 2]);
  end

  // Top transfer leaves as a +1 (add) or -1 (sub) digit of weight 2^W.
  assign w_arith_msd = w_op_add ? {w_c[W-1], 1'b0} : {1'b0, w_c[W-1]};

  always_comb begin
    w_nxt_acc = r_acc;
    w_nxt_msd = r_msd;
    case (op_e'(cmd_op))
      OP_LOAD: begin
        w_nxt_acc = w_load_acc;
        w_nxt_msd = SD_ZERO;
      end
      OP_SHL: begin
        w_nxt_acc = {r_acc[2*W-3:0], SD_ZERO};
        w_nxt_msd = sd_canon(r_acc[2*W-1:2*W-2]);
      end
      default: begin
        w_nxt_acc = w_arith_acc;
        w_nxt_msd = w_arith_msd;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc       <= '0;
      r_msd       <= SD_ZERO;
      r_res_valid <= 1'b0;
    end else if (w_accept) begin
      r_acc       <= w_nxt_acc;
      r_msd       <= w_nxt_msd;
      r_res_valid <= 1'b1;
    end else if (res_ready) begin
      r_res_valid <= 1'b0;
    end
  end

  assign acc       = r_acc;
  assign msd_out   = r_msd;
  assign res_valid = r_res_valid;

endmodule

// File: tb/tb_intdiv_sd2_acc.sv
// Purpose : self-checking bench for intdiv_sd2_acc at W=4, 8 and 16 driven in lock-step.
// Latency : n/a.
// Backpressure: res_ready driven by directed sequences and randomly.
module tb_intdiv_sd2_acc;

  localparam int WS [3] = '{4, 8, 16};

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        res_ready;
  logic [1:0]  cmd_op;
  logic [31:0] sd;
  logic [15:0] bin;

  logic        rdy4, rdy8, rdy16;
  logic        vld4, vld8, vld16;
  logic [7:0]  acc4;
  logic [15:0] acc8;
  logic [31:0] acc16;
  logic [1:0]  msd4, msd8, msd16;

  int n_checks = 0;
  int n_err    = 0;
  bit check_on = 1'b0;

  // Reference state: expected digits per instance, shared valid flag.
  logic [31:0] m_acc [3];
  logic [1:0]  m_msd [3];
  logic        m_vld;

  always #5 clk = ~clk;

  intdiv_sd2_acc #(.W(4)) u_w4 (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(rdy4), .cmd_op(cmd_op),
    .cmd_sd(sd[7:0]), .cmd_bin(bin[3:0]), .res_valid(vld4), .res_ready(res_ready),
    .acc(acc4), .msd_out(msd4));

  intdiv_sd2_acc #(.W(8)) u_w8 (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(rdy8), .cmd_op(cmd_op),
    .cmd_sd(sd[15:0]), .cmd_bin(bin[7:0]), .res_valid(vld8), .res_ready(res_ready),
    .acc(acc8), .msd_out(msd8));

  intdiv_sd2_acc #(.W(16)) u_w16 (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(rdy16), .cmd_op(cmd_op),
    .cmd_sd(sd), .cmd_bin(bin), .res_valid(vld16), .res_ready(res_ready),
    .acc(acc16), .msd_out(msd16));

  // ---------------- helpers ----------------
  function automatic int dval(input logic [1:0] d);
    return int'(d[1]) - int'(d[0]);
  endfunction

  function automatic logic [1:0] enc(input int v);
    if (v == 1)  return 2'b10;
    if (v == -1) return 2'b01;
    return 2'b00;
  endfunction

  function automatic longint sval(input logic [31:0] a, input int w);
    longint v = 0;
    for (int i = w - 1; i >= 0; i--) v = 2 * v + dval(a[2*i +: 2]);
    return v;
  endfunction

  function automatic bit has11(input logic [31:0] a, input int w);
    for (int i = 0; i < w; i++) if (a[2*i +: 2] == 2'b11) return 1'b1;
    return 1'b0;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Value-level model of one op: digit values via integer t = 2c+s / -2c+s splits.
  task automatic model_op(input int w, input logic [1:0] op, input logic [31:0] osd,
                          input logic [15:0] obin, input logic [31:0] old,
                          output logic [31:0] nacc, output logic [1:0] nmsd);
    int t, c, s, cprev;
    nacc  = '0;
    nmsd  = 2'b00;
    cprev = 0;
    case (op)
      2'b00: for (int i = 0; i < w; i++) nacc[2*i +: 2] = enc(dval(osd[2*i +: 2]));
      2'b11: begin
        for (int i = 1; i < w; i++) nacc[2*i +: 2] = enc(dval(old[2*(i-1) +: 2]));
        nmsd = enc(dval(old[2*(w-1) +: 2]));
      end
      2'b01: begin
        for (int i = 0; i < w; i++) begin
          t = dval(old[2*i +: 2]) - int'(obin[i]);
          c = (t < 0) ? 1 : 0;
          s = t + 2 * c;
          nacc[2*i +: 2] = enc(s - cprev);
          cprev = c;
        end
        nmsd = enc(-cprev);
      end
      default: begin
        for (int i = 0; i < w; i++) begin
          t = dval(old[2*i +: 2]) + int'(obin[i]);
          c = (t > 0) ? 1 : 0;
          s = t - 2 * c;
          nacc[2*i +: 2] = enc(cprev + s);
          cprev = c;
        end
        nmsd = enc(cprev);
      end
    endcase
  endtask

  // ---------------- reference model ----------------
  always @(posedge clk) begin
    logic [31:0] na;
    logic [1:0]  nm;
    if (rst) begin
      m_vld = 1'b0;
      for (int k = 0; k < 3; k++) begin m_acc[k] = '0; m_msd[k] = 2'b00; end
    end else if (cmd_valid && (!m_vld || res_ready)) begin
      for (int k = 0; k < 3; k++) begin
        model_op(WS[k], cmd_op, sd, bin, m_acc[k], na, nm);
        m_acc[k] = na;
        m_msd[k] = nm;
      end
      m_vld = 1'b1;
    end else if (res_ready) begin
      m_vld = 1'b0;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    logic [31:0] da;
    logic [1:0]  dm;
    logic        dv, dr;
    if (check_on) begin
      for (int k = 0; k < 3; k++) begin
        case (k)
          0:       begin da = {24'b0, acc4}; dm = msd4;  dv = vld4;  dr = rdy4;  end
          1:       begin da = {16'b0, acc8}; dm = msd8;  dv = vld8;  dr = rdy8;  end
          default: begin da = acc16;         dm = msd16; dv = vld16; dr = rdy16; end
        endcase
        chk($sformatf("w%0d res_valid", WS[k]), 64'(dv), 64'(m_vld));
        chk($sformatf("w%0d cmd_ready", WS[k]), 64'(dr), 64'(!m_vld || res_ready));
        chk($sformatf("w%0d acc", WS[k]), 64'(da), 64'(m_acc[k]));
        chk($sformatf("w%0d msd_out", WS[k]), 64'(dm), 64'(m_msd[k]));
        chk($sformatf("w%0d acc canonical", WS[k]), 64'(has11(da, WS[k])), 64'd0);
        chk($sformatf("w%0d msd canonical", WS[k]), 64'(dm == 2'b11), 64'd0);
      end
    end
  end

  // ---------------- directed + random stimulus ----------------
  task automatic send(input logic [1:0] op, input logic [31:0] osd, input logic [15:0] obin);
    bit ok = 1'b0;
    int n  = 0;
    cmd_valid = 1'b1;
    cmd_op    = op;
    sd        = osd;
    bin       = obin;
    do begin
      @(negedge clk);
      ok = rdy8;
      @(posedge clk);
      #1;
      n++;
    end while (!ok && n < 50);
    if (!ok) chk("send accept timeout", 64'd0, 64'd1);
    cmd_valid = 1'b0;
  endtask

  initial begin
    longint cum, prevv;
    int nv;
    rst       = 1'b1;
    cmd_valid = 1'b0;
    res_ready = 1'b1;
    cmd_op    = 2'b00;
    sd        = '0;
    bin       = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check_on = 1'b1;

    // Reset/idle state.
    @(negedge clk);
    chk("t1 acc", 64'(acc8), 64'h0000);
    chk("t1 msd", 64'(msd8), 64'd0);
    chk("t1 res_valid", 64'(vld8), 64'd0);
    chk("t1 cmd_ready", 64'(rdy8), 64'd1);
    @(posedge clk); #1;

    // 0 - 1 -> digits (+1,-1) = 16'h0006.
    send(2'b00, 32'h0, 16'h0);
    send(2'b01, 32'h0, 16'h0001);
    @(negedge clk);
    chk("t2 acc", 64'(acc8), 64'h0006);
    chk("t2 val", 64'(sval({16'b0, acc8}, 8)), 64'(-64'sd1));
    chk("t2 msd", 64'(msd8), 64'd0);
    @(posedge clk); #1;

    // 255 + 255 = 510 split between acc and msd, then -255 -> total 255.
    send(2'b00, 32'hAAAA_AAAA, 16'h0);
    send(2'b10, 32'h0, 16'h00FF);
    @(negedge clk);
    cum = 256 * dval(msd8);
    chk("t3 add acc", 64'(acc8), 64'hAAA8);
    chk("t3 add msd", 64'(msd8), 64'h2);
    chk("t3 add total", 64'(cum + sval({16'b0, acc8}, 8)), 64'd510);
    @(posedge clk); #1;
    send(2'b01, 32'h0, 16'h00FF);
    @(negedge clk);
    cum += 256 * dval(msd8);
    chk("t3 sub total", 64'(cum + sval({16'b0, acc8}, 8)), 64'd255);
    chk("t3 sub acc", 64'(acc8), 64'h0006);
    @(posedge clk); #1;

    // Stall: result held 3 clocks with a command waiting, applied exactly once.
    send(2'b00, 32'h0, 16'h0);
    res_ready = 1'b0;
    cmd_valid = 1'b1;
    cmd_op    = 2'b01;
    bin       = 16'h0003;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t4 stall cmd_ready", 64'(rdy8), 64'd0);
      chk("t4 stall acc", 64'(acc8), 64'h0000);
      chk("t4 stall res_valid", 64'(vld8), 64'd1);
      @(posedge clk); #1;
    end
    res_ready = 1'b1;
    @(negedge clk);
    chk("t4 release cmd_ready", 64'(rdy8), 64'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("t4 acc after sub3", 64'(acc8), 64'h0012);
    chk("t4 msd after sub3", 64'(msd8), 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t4 applied once", 64'(acc8), 64'h0012);
    chk("t4 res_valid drops", 64'(vld8), 64'd0);
    @(posedge clk); #1;

    // Back-to-back SUB 1 x4.
    prevv = sval({16'b0, acc8}, 8);
    nv = 0;
    cmd_valid = 1'b1;
    cmd_op    = 2'b01;
    bin       = 16'h0001;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (i == 3) cmd_valid = 1'b0;
      @(negedge clk);
      if (vld8) nv++;
      chk("t5 invariant", 64'(sval({16'b0, acc8}, 8) + 256 * dval(msd8)), 64'(prevv - 1));
      prevv = sval({16'b0, acc8}, 8);
    end
    chk("t5 consecutive valid", 64'(nv), 64'd4);
    @(posedge clk); #1;

    // Reset while a result is pending, with a command offered in the same cycle.
    send(2'b00, 32'h0000_9999, 16'h0);
    res_ready = 1'b0;
    @(negedge clk);
    chk("t6 pending", 64'(vld8), 64'd1);
    @(posedge clk); #1;
    rst       = 1'b1;
    cmd_valid = 1'b1;
    cmd_op    = 2'b00;
    sd        = 32'hAAAA_AAAA;
    @(posedge clk); #1;
    rst       = 1'b0;
    cmd_valid = 1'b0;
    res_ready = 1'b1;
    @(negedge clk);
    chk("t6 acc after rst", 64'(acc8), 64'h0);
    chk("t6 msd after rst", 64'(msd8), 64'h0);
    chk("t6 res_valid after rst", 64'(vld8), 64'd0);
    @(posedge clk); #1;

    // Random run across all widths.
    for (int i = 0; i < 10000; i++) begin
      cmd_valid = ($urandom_range(0, 3) != 0);
      cmd_op    = 2'($urandom_range(0, 3));
      sd        = $urandom;
      bin       = 16'($urandom);
      res_ready = ($urandom_range(0, 3) != 0);
      rst       = ($urandom_range(0, 499) == 0);
      @(posedge clk); #1;
    end
    rst       = 1'b0;
    cmd_valid = 1'b0;
    res_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
